// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants for the ID/EX boundary: opcodes, functs,
// ALU control codes, immediate-extension modes and forward selects.
package id_ex_stage_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8
    } alu_ctr_e;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_LUI   = 2'd2,
        EXT_SHAMT = 2'd3
    } ext_mode_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // M stage is newer than W, so its match wins when both hit.
    function automatic logic [1:0] fwd_pick(input logic m_hit, input logic w_hit);
        if (m_hit)
            return FWD_M;
        else if (w_hit)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decoder.sv
// Combinational main/ALU decoder: opcode + funct -> execute, memory and
// writeback controls. Unsupported encodings raise illegal with all writes off.
module alu_ctrl_decoder
    import id_ex_stage_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr,
    output logic       alu_src,
    output logic       reg_dst,
    output logic [1:0] ext_mode,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       mem_write,
    output logic       illegal
);

    // Decode the instruction class into its control bundle.
    always_comb begin
        alu_ctr    = ALU_ADD;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        ext_mode   = EXT_SIGN;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_ctr = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctr = ALU_SUB;
                    FN_AND:          alu_ctr = ALU_AND;
                    FN_OR:           alu_ctr = ALU_OR;
                    FN_XOR:          alu_ctr = ALU_XOR;
                    FN_NOR:          alu_ctr = ALU_NOR;
                    FN_SLT, FN_SLTU: alu_ctr = ALU_SLT;
                    // Shift amount travels as the B operand through SignImmE
                    FN_SLL: begin
                        alu_ctr  = ALU_SLL;
                        alu_src  = 1'b1;
                        ext_mode = EXT_SHAMT;
                    end
                    FN_SRL: begin
                        alu_ctr  = ALU_SRL;
                        alu_src  = 1'b1;
                        ext_mode = EXT_SHAMT;
                    end
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                alu_ctr   = ALU_SLT;
                alu_src   = 1'b1;
                reg_write = 1'b1;
            end
            OP_ANDI: begin
                alu_ctr   = ALU_AND;
                alu_src   = 1'b1;
                ext_mode  = EXT_ZERO;
                reg_write = 1'b1;
            end
            OP_ORI: begin
                alu_ctr   = ALU_OR;
                alu_src   = 1'b1;
                ext_mode  = EXT_ZERO;
                reg_write = 1'b1;
            end
            OP_XORI: begin
                alu_ctr   = ALU_XOR;
                alu_src   = 1'b1;
                ext_mode  = EXT_ZERO;
                reg_write = 1'b1;
            end
            OP_LUI: begin
                alu_src   = 1'b1;
                ext_mode  = EXT_LUI;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            // Control flow is resolved in decode; E only sees a harmless subtract
            OP_BEQ, OP_BNE, OP_J: begin
                alu_ctr = ALU_SUB;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with forwarding-select generation
// and load-use hazard detection (one bubble per dependent load).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [REG_W-1:0]  WriteRegM,
    input  logic              RegWriteM,
    input  logic [REG_W-1:0]  WriteRegW,
    input  logic              RegWriteW,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] SignImmE,
    output logic [3:0]        ALUCtrE,
    output logic              ALUSrcE,
    output logic              RegWriteE,
    output logic              MemtoRegE,
    output logic              MemWriteE,
    output logic [REG_W-1:0]  RsE,
    output logic [REG_W-1:0]  RtE,
    output logic [REG_W-1:0]  WriteRegE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              LwStallD,
    output logic              IllegalE
);

    // Instruction fields
    logic [5:0]       instr_op;
    logic [5:0]       instr_funct;
    logic [REG_W-1:0] f_rs;
    logic [REG_W-1:0] f_rt;
    logic [REG_W-1:0] f_rd;
    logic [4:0]       f_shamt;
    logic [15:0]      f_imm;

    assign instr_op    = InstrD[31:26];
    assign instr_funct = InstrD[5:0];
    assign f_rs        = InstrD[25:21];
    assign f_rt        = InstrD[20:16];
    assign f_rd        = InstrD[15:11];
    assign f_shamt     = InstrD[10:6];
    assign f_imm       = InstrD[15:0];

    // Decoder outputs
    logic [3:0] dec_alu_ctr;
    logic       dec_alu_src;
    logic       dec_reg_dst;
    logic [1:0] dec_ext_mode;
    logic       dec_reg_write;
    logic       dec_mem_to_reg;
    logic       dec_mem_write;
    logic       dec_illegal;

    alu_ctrl_decoder u_dec (
        .op         (instr_op),
        .funct      (instr_funct),
        .alu_ctr    (dec_alu_ctr),
        .alu_src    (dec_alu_src),
        .reg_dst    (dec_reg_dst),
        .ext_mode   (dec_ext_mode),
        .reg_write  (dec_reg_write),
        .mem_to_reg (dec_mem_to_reg),
        .mem_write  (dec_mem_write),
        .illegal    (dec_illegal)
    );

    // E register bank
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] sign_imm_q, sign_imm_d;
    logic [3:0]        alu_ctr_q, alu_ctr_d;
    logic              alu_src_q, alu_src_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              mem_write_q, mem_write_d;
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  write_reg_q, write_reg_d;
    logic              illegal_q, illegal_d;

    logic              lw_stall;
    logic              is_shift;
    logic [REG_W-1:0]  write_reg_sel;
    logic [DATA_W-1:0] imm_ext;

    // Load in E whose destination is read by the instruction in D.
    assign lw_stall = mem_to_reg_q && (rt_q != '0) && ((rt_q == f_rs) || (rt_q == f_rt));

    assign is_shift      = (dec_ext_mode == EXT_SHAMT);
    assign write_reg_sel = dec_reg_dst ? f_rd : f_rt;

    // Form the B-side immediate according to the decoded extension mode.
    always_comb begin
        imm_ext = DATA_W'($signed(f_imm));
        case (dec_ext_mode)
            EXT_ZERO:  imm_ext = DATA_W'(f_imm);
            EXT_LUI:   imm_ext = DATA_W'({f_imm, 16'h0000});
            EXT_SHAMT: imm_ext = DATA_W'(f_shamt);
            default:   imm_ext = DATA_W'($signed(f_imm));
        endcase
    end

    // Next E contents: hold on stall, bubble on flush/load-use/illegal, else capture.
    always_comb begin
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        sign_imm_d   = sign_imm_q;
        alu_ctr_d    = alu_ctr_q;
        alu_src_d    = alu_src_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        mem_write_d  = mem_write_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        write_reg_d  = write_reg_q;
        illegal_d    = illegal_q;
        if (!StallE) begin
            if (FlushE || lw_stall || dec_illegal) begin
                rd1_d        = '0;
                rd2_d        = '0;
                sign_imm_d   = '0;
                alu_ctr_d    = ALU_ADD;
                alu_src_d    = 1'b0;
                reg_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                mem_write_d  = 1'b0;
                rs_d         = '0;
                rt_d         = '0;
                write_reg_d  = '0;
                // Only a genuinely captured bad encoding is flagged
                illegal_d    = !FlushE && !lw_stall && dec_illegal;
            end else begin
                // Shifts operate on rt through the A port, so rt is renamed to rs
                rd1_d        = is_shift ? RD2D : RD1D;
                rd2_d        = RD2D;
                sign_imm_d   = imm_ext;
                alu_ctr_d    = dec_alu_ctr;
                alu_src_d    = dec_alu_src;
                reg_write_d  = dec_reg_write && (write_reg_sel != '0);
                mem_to_reg_d = dec_mem_to_reg;
                mem_write_d  = dec_mem_write;
                rs_d         = is_shift ? f_rt : f_rs;
                rt_d         = is_shift ? '0 : f_rt;
                write_reg_d  = write_reg_sel;
                illegal_d    = 1'b0;
            end
        end
    end

    // E pipeline register; async reset leaves a bubble in E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q        <= '0;
            rd2_q        <= '0;
            sign_imm_q   <= '0;
            alu_ctr_q    <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            rs_q         <= '0;
            rt_q         <= '0;
            write_reg_q  <= '0;
            illegal_q    <= 1'b0;
        end else begin
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            sign_imm_q   <= sign_imm_d;
            alu_ctr_q    <= alu_ctr_d;
            alu_src_q    <= alu_src_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            write_reg_q  <= write_reg_d;
            illegal_q    <= illegal_d;
        end
    end

    assign RD1E      = rd1_q;
    assign RD2E      = rd2_q;
    assign SignImmE  = sign_imm_q;
    assign ALUCtrE   = alu_ctr_q;
    assign ALUSrcE   = alu_src_q;
    assign RegWriteE = reg_write_q;
    assign MemtoRegE = mem_to_reg_q;
    assign MemWriteE = mem_write_q;
    assign RsE       = rs_q;
    assign RtE       = rt_q;
    assign WriteRegE = write_reg_q;
    assign IllegalE  = illegal_q;
    assign LwStallD  = lw_stall;

    // $0 is never forwarded; it always reads as zero from the register file.
    assign ForwardAE = fwd_pick(RegWriteM && (WriteRegM == rs_q) && (rs_q != '0),
                                RegWriteW && (WriteRegW == rs_q) && (rs_q != '0));
    assign ForwardBE = fwd_pick(RegWriteM && (WriteRegM == rt_q) && (rt_q != '0),
                                RegWriteW && (WriteRegW == rt_q) && (rt_q != '0));

endmodule
